// File: rtl/cpu8_out_pkg.sv
// ---------------------------------------------------------------------------
// cpu8_out_pkg
// Shared definitions for the CPU8 result-byte UART transmitter:
//   - txState_t     : serializer FSM state encoding (2 bits)
//   - DEF_CLKS_PER_BIT : default clocks per UART bit period
//   - DEF_FIFO_DEPTH   : default byte-buffer depth (power of two)
//   - FRAME_BITS       : bits per 8N1 frame (start + 8 data + stop)
// ---------------------------------------------------------------------------
package cpu8_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } txState_t;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_FIFO_DEPTH   = 8;
  localparam int FRAME_BITS       = 10;

endpackage

// File: rtl/cpu8_out_fifo.sv
// ---------------------------------------------------------------------------
// cpu8_out_fifo
// Synchronous byte FIFO with a registered occupancy count.
// Ports:
//   i_clk       : clock, rising edge
//   i_resetN    : asynchronous active-low reset (clears pointers and count)
//   i_push      : write i_pushData this edge (ignored while full)
//   i_pushData  : byte to write
//   i_pop       : advance the read pointer this edge (ignored while empty)
//   o_popData   : byte at the head of the FIFO (valid while not empty)
//   o_count     : number of bytes currently stored, 0..DEPTH
//   o_full      : o_count == DEPTH
//   o_empty     : o_count == 0
// ---------------------------------------------------------------------------
module cpu8_out_fifo
  import cpu8_out_pkg::*;
#(
  parameter  int DEPTH = DEF_FIFO_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_resetN,
  input  logic          i_push,
  input  logic [7:0]    i_pushData,
  input  logic          i_pop,
  output logic [7:0]    o_popData,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_doPush  = i_push && !o_full;
  assign w_doPop   = i_pop && !o_empty;
  assign o_popData = r_mem[r_rdPtr];
  assign o_count   = r_count;

  // Storage array has no reset: stale contents are unreachable once the
  // pointers and count are cleared, so only the control state is reset.
  always_ff @(posedge i_clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  // Pointers are exactly log2(DEPTH) bits so they wrap modulo DEPTH on
  // their own. A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cpu8_out_uart.sv
// ---------------------------------------------------------------------------
// cpu8_out_uart
// Buffers CPU8 result bytes in a small FIFO and serialises them as UART 8N1.
// Ports:
//   clk          : clock, rising edge
//   master_reset : asynchronous active-low reset; aborts any frame in flight
//   out_data     : result byte from the CPU
//   out_valid    : out_data is valid this cycle
//   out_ready    : FIFO can accept a byte (not full)
//   tx           : registered serial line, idle high
//   tx_busy      : serializer is in a frame (not IDLE)
//   fifo_count   : bytes currently buffered
//   overflow     : sticky; a byte arrived while full and was dropped
// ---------------------------------------------------------------------------
module cpu8_out_uart
  import cpu8_out_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       master_reset,
  input  logic [7:0] out_data,
  input  logic       out_valid,
  output logic       out_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic [3:0] fifo_count,
  output logic       overflow
);

  localparam int         CW            = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0] BAUD_LAST     = 8'(CLKS_PER_BIT - 1);
  // Index of the last data bit: frame minus start and stop bits, minus one.
  localparam logic [2:0] LAST_DATA_BIT = 3'(FRAME_BITS - 3);

  txState_t      r_state;
  logic [7:0]    r_baudCnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_overflow;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_bitDone;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;

  // Acceptance uses the registered full flag, so a pop on the same edge
  // never makes room for a byte offered while full.
  assign w_push     = out_valid && !w_full;
  assign w_pop      = (r_state == ST_IDLE) && !w_empty;
  assign w_bitDone  = (r_baudCnt == BAUD_LAST);

  assign out_ready  = !w_full;
  assign tx         = r_tx;
  assign tx_busy    = (r_state != ST_IDLE);
  assign fifo_count = 4'(w_count);
  assign overflow   = r_overflow;

  cpu8_out_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clk),
    .i_resetN   (master_reset),
    .i_push     (w_push),
    .i_pushData (out_data),
    .i_pop      (w_pop),
    .o_popData  (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Serializer. tx is registered and updated on the same edge as each state
  // or bit change, so each line level is held for exactly CLKS_PER_BIT
  // cycles. In DATA the next bit is driven from shift[1] while shifting, so
  // the line always shows the bit that is at shift[0] after the edge.
  always_ff @(posedge clk or negedge master_reset) begin
    if (!master_reset) begin
      r_state   <= ST_IDLE;
      r_baudCnt <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_head;
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_tx      <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_bitDone) begin
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_tx      <= r_shift[0];
            r_state   <= ST_DATA;
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_bitDone) begin
            r_baudCnt <= '0;
            if (r_bitIdx == LAST_DATA_BIT) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_tx     <= r_shift[1];
              r_shift  <= {1'b0, r_shift[7:1]};
              r_bitIdx <= r_bitIdx + 1'b1;
            end
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bitDone) begin
            r_baudCnt <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_baudCnt <= r_baudCnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  // Sticky drop flag: only a reset clears it.
  always_ff @(posedge clk or negedge master_reset) begin
    if (!master_reset) begin
      r_overflow <= 1'b0;
    end else if (out_valid && w_full) begin
      r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu8_out_uart.sv
// ---------------------------------------------------------------------------
// tb_cpu8_out_uart
// Self-checking bench for cpu8_out_uart with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// A frame-level model (byte queue plus "cycles into current frame") predicts
// every output each cycle; a line decoder recovers transmitted bytes.
// ---------------------------------------------------------------------------
module tb_cpu8_out_uart;

  localparam int CPB          = 4;
  localparam int DEPTH        = 8;
  localparam int FRAME_CYCLES = 10 * CPB;

  logic       clk          = 1'b0;
  logic       master_reset = 1'b1;
  logic [7:0] out_data     = 8'h00;
  logic       out_valid    = 1'b0;
  logic       out_ready;
  logic       tx;
  logic       tx_busy;
  logic [3:0] fifo_count;
  logic       overflow;

  int nCompared   = 0;
  int nMismatched = 0;
  bit checkEn     = 1'b0;
  int peakCount   = 0;

  // Model state
  logic [7:0] mQ[$];
  logic [7:0] mLog[$];
  bit         mActive   = 1'b0;
  int         mElapsed  = 0;
  logic [7:0] mByte     = 8'h00;
  bit         mOverflow = 1'b0;

  // Decoder state
  logic [7:0] rxQ[$];
  logic [7:0] wantQ[$];
  bit         rxActive = 1'b0;
  int         rxCnt    = 0;
  logic [7:0] rxByte   = 8'h00;

  cpu8_out_uart #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .master_reset (master_reset),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Present one input beat; it is sampled on the next rising edge.
  task automatic applyStimulus(input bit v, input logic [7:0] d);
    out_valid = v;
    out_data  = d;
    @(posedge clk);
    #2;
    out_valid = 1'b0;
  endtask

  // Idle the inputs until the transmitter has drained, within a budget.
  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    while ((tx_busy || fifo_count != 0) && n < budget) begin
      applyStimulus(1'b0, 8'h00);
      n++;
    end
    checkOutput({name, "_drain"}, int'(tx_busy || fifo_count != 0), 0);
  endtask

  task automatic checkRx(input string name);
    checkOutput({name, "_frames"}, rxQ.size(), wantQ.size());
    for (int i = 0; i < wantQ.size() && i < rxQ.size(); i++) begin
      checkOutput({name, "_byte"}, int'(rxQ[i]), int'(wantQ[i]));
    end
  endtask

  task automatic clearLogs();
    rxQ.delete();
    mLog.delete();
    wantQ.delete();
  endtask

  // Behavioural model: a byte queue plus the position inside the current
  // frame. An idle serializer takes the head byte; a frame lasts
  // FRAME_CYCLES cycles and is followed by at least one idle cycle.
  always @(posedge clk or negedge master_reset) begin
    bit full;
    bit takeHead;
    if (!master_reset) begin
      mQ.delete();
      mActive   = 1'b0;
      mElapsed  = 0;
      mOverflow = 1'b0;
    end else begin
      full     = (mQ.size() == DEPTH);
      takeHead = !mActive && (mQ.size() != 0);
      if (out_valid && full) mOverflow = 1'b1;
      if (mActive) begin
        mElapsed++;
        if (mElapsed == FRAME_CYCLES) mActive = 1'b0;
      end else if (takeHead) begin
        mByte    = mQ.pop_front();
        mActive  = 1'b1;
        mElapsed = 0;
      end
      if (out_valid && !full) begin
        mQ.push_back(out_data);
        mLog.push_back(out_data);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int   bitNo;
    logic expTx;
    if (checkEn) begin
      expTx = 1'b1;
      if (mActive) begin
        bitNo = mElapsed / CPB;
        if (bitNo == 0)      expTx = 1'b0;
        else if (bitNo == 9) expTx = 1'b1;
        else                 expTx = mByte[bitNo-1];
      end
      checkOutput("tx", int'(tx), int'(expTx));
      checkOutput("tx_busy", int'(tx_busy), int'(mActive));
      checkOutput("fifo_count", int'(fifo_count), mQ.size());
      checkOutput("out_ready", int'(out_ready), int'(mQ.size() != DEPTH));
      checkOutput("overflow", int'(overflow), int'(mOverflow));
      if (int'(fifo_count) > peakCount) peakCount = int'(fifo_count);
    end
  end

  // Line decoder: finds the start bit and samples each bit mid-period.
  always @(negedge clk) begin
    int bitNo;
    if (!master_reset) begin
      rxActive = 1'b0;
      rxCnt    = 0;
    end else if (!rxActive) begin
      if (checkEn && tx == 1'b0) begin
        rxActive = 1'b1;
        rxCnt    = 0;
      end
    end else begin
      rxCnt++;
      if (rxCnt % CPB == CPB / 2) begin
        bitNo = rxCnt / CPB;
        if (bitNo >= 1 && bitNo <= 8) begin
          rxByte[bitNo-1] = tx;
        end else if (bitNo == 9) begin
          checkOutput("stop_bit", int'(tx), 1);
          rxQ.push_back(rxByte);
          rxActive = 1'b0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   a5Line[10];
    int   busyCnt;
    logic [7:0] b;
    a5Line = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    // Reset state
    #1 master_reset = 1'b0;
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("rst_tx", int'(tx), 1);
    checkOutput("rst_busy", int'(tx_busy), 0);
    checkOutput("rst_count", int'(fifo_count), 0);
    checkOutput("rst_ready", int'(out_ready), 1);
    checkOutput("rst_ovf", int'(overflow), 0);
    @(posedge clk);
    #2 master_reset = 1'b1;

    // Single byte 0xA5: latency and exact line sequence
    $display("[TB] single byte 0xA5");
    clearLogs();
    applyStimulus(1'b1, 8'hA5);
    @(negedge clk);
    checkOutput("a5_latency_idle", int'(tx), 1);
    busyCnt = 0;
    for (int i = 0; i < FRAME_CYCLES; i++) begin
      @(negedge clk);
      checkOutput("a5_line", int'(tx), a5Line[i / CPB]);
      if (tx_busy) busyCnt++;
    end
    @(negedge clk);
    checkOutput("a5_busy_after", int'(tx_busy), 0);
    checkOutput("a5_busy_cycles", busyCnt, 40);
    wantQ.push_back(8'hA5);
    waitIdle("a5", 200);
    checkRx("a5");

    // Burst of 8 bytes
    $display("[TB] burst of 8");
    clearLogs();
    peakCount = 0;
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i));
    waitIdle("burst8", 800);
    checkOutput("burst8_peak", peakCount, 7);
    checkOutput("burst8_ovf", int'(overflow), 0);
    for (int i = 1; i <= 8; i++) wantQ.push_back(8'(i));
    checkRx("burst8");

    // Burst of 10 bytes: tenth is dropped
    $display("[TB] burst of 10");
    clearLogs();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h10 + i));
    @(negedge clk);
    checkOutput("burst10_ovf_set", int'(overflow), 1);
    checkOutput("burst10_full", int'(fifo_count), 8);
    waitIdle("burst10", 800);
    checkOutput("burst10_ovf_sticky", int'(overflow), 1);
    for (int i = 0; i < 9; i++) wantQ.push_back(8'(8'h10 + i));
    checkRx("burst10");

    // Push 0x3C on the same edge as a pop with three bytes buffered
    $display("[TB] push during pop");
    clearLogs();
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33);
    applyStimulus(1'b1, 8'h44);
    repeat (38) applyStimulus(1'b0, 8'h00);
    @(negedge clk);
    checkOutput("pp_count_before", int'(fifo_count), 3);
    checkOutput("pp_idle_before", int'(tx_busy), 0);
    applyStimulus(1'b1, 8'h3C);
    @(negedge clk);
    checkOutput("pp_count_after", int'(fifo_count), 3);
    checkOutput("pp_busy_after", int'(tx_busy), 1);
    waitIdle("pushpop", 800);
    wantQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h3C};
    checkRx("pushpop");

    // Reset during DATA bit 4
    $display("[TB] reset mid-frame");
    clearLogs();
    applyStimulus(1'b1, 8'hC3);
    applyStimulus(1'b1, 8'h96);
    applyStimulus(1'b1, 8'h69);
    repeat (20) applyStimulus(1'b0, 8'h00);
    checkOutput("mid_busy_before", int'(tx_busy), 1);
    #1 master_reset = 1'b0;
    #1;
    checkOutput("mid_rst_tx", int'(tx), 1);
    checkOutput("mid_rst_count", int'(fifo_count), 0);
    checkOutput("mid_rst_ovf", int'(overflow), 0);
    checkOutput("mid_rst_busy", int'(tx_busy), 0);
    checkOutput("mid_rst_ready", int'(out_ready), 1);
    repeat (3) applyStimulus(1'b1, 8'hEE);
    master_reset = 1'b1;
    clearLogs();
    applyStimulus(1'b1, 8'h5A);
    waitIdle("after_rst", 200);
    checkOutput("after_rst_ovf", int'(overflow), 0);
    wantQ.push_back(8'h5A);
    checkRx("after_rst");

    // Pointer wrap: 20 bytes, one per frame
    $display("[TB] pointer wrap");
    clearLogs();
    peakCount = 0;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      wantQ.push_back(b);
      applyStimulus(1'b1, b);
      repeat (40) applyStimulus(1'b0, 8'h00);
    end
    waitIdle("wrap", 200);
    checkOutput("wrap_peak", peakCount, 1);
    checkRx("wrap");

    // Random traffic: a dense phase then a sparse phase
    $display("[TB] random traffic");
    clearLogs();
    repeat (200) applyStimulus(($urandom_range(0, 2) == 0), 8'($urandom));
    repeat (400) applyStimulus(($urandom_range(0, 29) == 0), 8'($urandom));
    waitIdle("rand", 2000);
    wantQ = mLog;
    checkRx("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
